iter_divider: RTL
=================

ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 The block SHALL have parameter: IS_SIGNED, 1, 1 = two's-complement divide/modulo, 0 = unsigned.
REQ-002 The block SHALL have port: clk  in  1  rising-edge clock.
REQ-003 The block SHALL have port: resetn  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have port: s_axis_dividend_tdata  in  32  dividend.
REQ-005 The block SHALL have port: s_axis_dividend_tvalid  in  1  dividend offered.
REQ-006 The block SHALL have port: s_axis_dividend_tready  out  1  dividend can be accepted.
REQ-007 The block SHALL have port: s_axis_divisor_tdata  in  32  divisor.
REQ-008 The block SHALL have port: s_axis_divisor_tvalid  in  1  divisor offered.
REQ-009 The block SHALL have port: s_axis_divisor_tready  out  1  divisor can be accepted.
REQ-010 The block SHALL have port: m_axis_dout_tdata  out  64  {quotient[63:32], remainder[31:0]}.
REQ-011 The block SHALL have port: m_axis_dout_tvalid  out  1  result valid.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-013 Both tready outputs SHALL be identical and high exactly in IDLE and DONE.
REQ-014 An accept SHALL occur on a rising edge where both tvalid and tready are high; both operands are captured on that edge.
REQ-015 One tvalid high without the other SHALL NOT be accepted, and the block SHALL NOT capture a partial operand.
REQ-016 On accept the block SHALL enter CALC with iteration counter 0. From DONE, it SHALL clear m_axis_dout_tvalid on the same edge.
REQ-017 CALC SHALL run restoring radix-2 shift-subtract: one quotient bit per cycle, MSB first, on operand magnitudes, 32 cycles.
REQ-018 After the 32nd iteration edge the FSM SHALL enter DONE. m_axis_dout_tvalid SHALL be high from the 33rd edge after accept.
REQ-019 m_axis_dout_tvalid and m_axis_dout_tdata SHALL stay stable in DONE until the next accept (no output back-pressure).
REQ-020 With IS_SIGNED=1, magnitudes SHALL be computed from both operands. The quotient SHALL be negated when operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-021 With IS_SIGNED=1, 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0x00000000.
REQ-022 Divide by zero, unsigned, SHALL give quotient 0xFFFFFFFF and remainder = dividend.
REQ-023 Divide by zero, signed, SHALL give remainder = dividend and quotient 0xFFFFFFFF if dividend ≥ 0, else 0x00000001.
REQ-024 Divide by zero SHALL take the same latency as any other division, with no early exit.
REQ-025 Inputs changing during CALC SHALL have no effect.
REQ-026 m_axis_dout_tdata SHALL read 0 in IDLE.

Reset
REQ-027 resetn low SHALL asynchronously force: state IDLE; counter, partial remainder, quotient and result registers 0; m_axis_dout_tvalid 0; tready outputs 1 once deasserted.
REQ-028 Reset during CALC or DONE SHALL abort the operation without producing a result.
REQ-029 Reset SHALL be released synchronously to clk by the instantiating level. The block SHALL NOT add a synchronizer.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, DATA_W=32 and ITER_CNT_W=5.
REQ-031 No sub-module is needed. Sign pre/post-processing and the iteration datapath SHALL be inline in one module.
REQ-032 Two instances (IS_SIGNED=1 and IS_SIGNED=0) SHALL be drop-in replacements for the EXE-stage divider IPs with identical port names.

Verification
REQ-033 Unsigned: 100 / 7 -> dout_tvalid on edge 33 after accept, tdata = {0x0000000E, 0x00000002}.
REQ-034 Signed: -7 / 2 -> {0xFFFFFFFD, 0xFFFFFFFF}. Signed: 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}.
REQ-035 Divide by zero: unsigned 5/0 -> {0xFFFFFFFF, 0x00000005}; signed -5/0 -> {0x00000001, 0xFFFFFFFB}; both with 33-cycle latency.
REQ-036 Handshake: dividend tvalid high 3 cycles before divisor tvalid -> accept only on the first cycle both are high; tready low throughout CALC.
REQ-037 Back-to-back: new operands presented while in DONE -> accepted on that edge, dout_tvalid drops next cycle, second result correct 33 edges later.
REQ-038 Reset: resetn pulsed low at iteration 10 -> outputs cleared immediately, no dout_tvalid afterwards; the next operation completes normally.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative 32-bit divider: FSM encoding,
// datapath widths and the two's-complement magnitude helper.
package iter_divider_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_CNT_W = 5;

  // Counter value of the final shift-subtract iteration.
  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Absolute value of a two's-complement word when neg is set.
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude 2^31.
  function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v,
                                               input logic              neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Operand / result bundle of the divider. The master side is the
// producer of operands (pipeline stage or bench); the slave side is the
// divider itself.
interface iter_divider_if;
  import iter_divider_pkg::*;

  logic [DATA_W-1:0]   dividend_tdata;
  logic                dividend_tvalid;
  logic                dividend_tready;
  logic [DATA_W-1:0]   divisor_tdata;
  logic                divisor_tvalid;
  logic                divisor_tready;
  logic [2*DATA_W-1:0] dout_tdata;
  logic                dout_tvalid;

  modport master (
    output dividend_tdata, dividend_tvalid, divisor_tdata, divisor_tvalid,
    input  dividend_tready, divisor_tready, dout_tdata, dout_tvalid
  );

  modport slave (
    input  dividend_tdata, dividend_tvalid, divisor_tdata, divisor_tvalid,
    output dividend_tready, divisor_tready, dout_tdata, dout_tvalid
  );

endinterface

// File: rtl/iter_divider.sv
// Iterative restoring radix-2 divider, 32 quotient bits MSB first, with
// optional two's-complement pre/post processing. Flat port names match
// the pipeline's existing divider IP so it drops straight in.
//
// Handshake: an operand pair is accepted on a rising edge where both
// s_axis_*_tvalid and the shared tready are high; one valid without the
// other is ignored. tready is high only in IDLE and DONE. The result has
// no back-pressure: dout_tvalid/dout_tdata hold in DONE until the next
// accept, which clears dout_tvalid on that same edge.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int IS_SIGNED = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [DATA_W-1:0]   s_axis_dividend_tdata,
  input  logic                s_axis_dividend_tvalid,
  output logic                s_axis_dividend_tready,
  input  logic [DATA_W-1:0]   s_axis_divisor_tdata,
  input  logic                s_axis_divisor_tvalid,
  output logic                s_axis_divisor_tready,
  output logic [2*DATA_W-1:0] m_axis_dout_tdata,
  output logic                m_axis_dout_tvalid
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ITER_CNT_W-1:0] r_cnt;
  logic                  r_post;      // all iterations done, apply signs next edge
  logic [DATA_W-1:0]     r_rem;       // partial remainder
  logic [DATA_W-1:0]     r_quo;       // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]     r_dsr;       // divisor magnitude
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_dout_tvalid;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_dvd_neg;
  logic                  w_dsr_neg;
  logic [DATA_W:0]       w_shift;
  logic [DATA_W:0]       w_diff;
  logic                  w_fits;
  logic [DATA_W-1:0]     w_rem_nxt;
  logic [DATA_W-1:0]     w_quo_nxt;
  logic [DATA_W-1:0]     w_q_final;
  logic [DATA_W-1:0]     w_r_final;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = w_ready && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

  assign w_dvd_neg = (IS_SIGNED != 0) && s_axis_dividend_tdata[DATA_W-1];
  assign w_dsr_neg = (IS_SIGNED != 0) && s_axis_divisor_tdata[DATA_W-1];

  // One restoring step: shift in the next dividend bit and subtract the
  // divisor if it fits. A zero divisor always fits, which naturally gives
  // an all-ones quotient and remainder = dividend magnitude.
  assign w_shift   = {r_rem, r_quo[DATA_W-1]};
  assign w_diff    = w_shift - {1'b0, r_dsr};
  assign w_fits    = ~w_diff[DATA_W];
  assign w_rem_nxt = w_fits ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign w_quo_nxt = {r_quo[DATA_W-2:0], w_fits};

  assign w_q_final = f_mag(r_quo, r_neg_q);
  assign w_r_final = f_mag(r_rem, r_neg_r);

  assign s_axis_dividend_tready = w_ready;
  assign s_axis_divisor_tready  = w_ready;
  assign m_axis_dout_tdata      = r_result;
  assign m_axis_dout_tvalid     = r_dout_tvalid;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic: accept from IDLE/DONE, leave CALC after sign fix-up.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_accept) w_state_nxt = ST_CALC;
      ST_CALC:          if (r_post)   w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture magnitudes on accept, iterate 32 times, then
  // register the sign-corrected result one edge later (edge 33).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt         <= '0;
      r_post        <= 1'b0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dsr         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_result      <= '0;
      r_dout_tvalid <= 1'b0;
    end else if (w_accept) begin
      r_cnt         <= '0;
      r_post        <= 1'b0;
      r_rem         <= '0;
      r_quo         <= f_mag(s_axis_dividend_tdata, w_dvd_neg);
      r_dsr         <= f_mag(s_axis_divisor_tdata, w_dsr_neg);
      r_neg_q       <= w_dvd_neg ^ w_dsr_neg;
      r_neg_r       <= w_dvd_neg;
      r_result      <= '0;
      r_dout_tvalid <= 1'b0;
    end else if (r_state == ST_CALC) begin
      if (!r_post) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        if (r_cnt == LAST_ITER) r_post <= 1'b1;
        else                    r_cnt  <= r_cnt + ITER_CNT_W'(1);
      end else begin
        r_result      <= {w_q_final, w_r_final};
        r_dout_tvalid <= 1'b1;
        r_post        <= 1'b0;
      end
    end
  end

endmodule
